// File: rtl/boruss_loader_pkg.sv
// Shared definitions for the Boruss program loader: FSM state encodings,
// load_error codes and the default frame header byte.
package boruss_loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB5;

endpackage

// File: rtl/boruss_loader_timeout.sv
// Idle-cycle counter for the loader: counts enabled cycles since the last
// clear and flags expiry on the cycle that completes TIMEOUT_CYCLES idle cycles.
module boruss_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Expiry is decoded from the registered count so the owner can abort in
  // the same cycle, before the counter itself would reach TIMEOUT_CYCLES.
  always_comb begin
    expired = enable && (count_q == LIMIT);
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (!expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/boruss_program_loader.sv
// Framed byte-stream program loader: writes a checksummed image into program
// memory from address 0 and holds the CPU in reset until a good frame lands.
module boruss_program_loader
  import boruss_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic [1:0] load_error,
  output logic [2:0] loader_state
);

  loader_state_e state_q, state_d;
  logic [7:0] index_q, index_d;
  logic [8:0] count_q, count_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] err_q, err_d;
  logic       mem_we_q, mem_we_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic       cpu_hold_q, cpu_hold_d;
  logic       load_done_q, load_done_d;

  logic       accept;
  logic       tmo_enable;
  logic       tmo_clear;
  logic       tmo_expired;
  logic [7:0] csum_sum;

  boruss_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (tmo_enable),
    .clear   (tmo_clear),
    .expired (tmo_expired)
  );

  // A byte offered in the expiring cycle must not be handshaked, so the
  // state decode of rx_ready is gated by the timeout.
  always_comb begin
    tmo_enable = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    rx_ready   = ((state_q == ST_SYNC) || tmo_enable) && !tmo_expired;
    accept     = rx_valid && rx_ready;
    csum_sum   = acc_q + rx_data;
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    count_d     = count_q;
    acc_d       = acc_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_SYNC: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
          err_d   = ERR_NONE;
          index_d = '0;
          acc_d   = '0;
        end
      end
      ST_LEN: begin
        if (tmo_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (accept) begin
          count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tmo_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (accept) begin
          acc_d       = csum_sum;
          mem_we_d    = 1'b1;
          mem_addr_d  = index_q;
          mem_wdata_d = rx_data;
          index_d     = index_q + 8'd1;
          count_d     = count_q - 9'd1;
          if (count_q == 9'd1) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (tmo_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (accept) begin
          if (csum_sum == 8'h00) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_CSUM;
          end
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_SYNC;
      default:  state_d = ST_SYNC;
    endcase

    cpu_hold_d  = (state_d != ST_DONE);
    load_done_d = (state_d == ST_DONE);
    tmo_clear   = accept || (state_d != state_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      index_q     <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      err_q       <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    mem_we       = mem_we_q;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    cpu_hold     = cpu_hold_q;
    load_done    = load_done_q;
    load_error   = err_q;
    loader_state = state_q;
  end

endmodule

// File: tb/tb_boruss_program_loader.sv
// Directed bench for boruss_program_loader: a table of whole frames with
// expected outcomes plus hand-written timeout, reset and 256-byte sequences.
module tb_boruss_program_loader;

  localparam int unsigned T = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic [1:0] load_error;
  logic [2:0] loader_state;

  boruss_program_loader #(
    .TIMEOUT_CYCLES(T),
    .SYNC_BYTE     (8'hB5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .loader_state (loader_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  int         err_cycles = 0;
  int         done_cyc   = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (loader_state == 3'd5) err_cycles++;
    if (load_done && done_cyc < 0) done_cyc = cyc;
  end

  typedef struct {
    logic [7:0]  b [0:7];
    int unsigned n;
    int unsigned data_off;
    int unsigned exp_writes;
    logic        exp_done;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    err_cycles = 0;
    done_cyc   = -1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns #1 after the edge on which it transferred.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got      = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (rx_ready) got = 1'b1;
      else @(posedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      failures++;
      $display("FAIL handshake: byte %0h not accepted within 64 cycles", b);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_load_error"}, load_error, 0);
    chk({tag, "_state"}, loader_state, 0);
  endtask

  initial begin
    int bad;
    int k;

    vecs[0] = '{b: '{8'hB5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A, 8'h00, 8'h00},
                n: 6, data_off: 2, exp_writes: 3, exp_done: 1'b1, exp_err: 2'b00};
    vecs[1] = '{b: '{8'hB5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00},
                n: 5, data_off: 2, exp_writes: 2, exp_done: 1'b0, exp_err: 2'b01};
    vecs[2] = '{b: '{8'h10, 8'hFF, 8'hB5, 8'h01, 8'h7F, 8'h81, 8'h00, 8'h00},
                n: 6, data_off: 4, exp_writes: 1, exp_done: 1'b1, exp_err: 2'b00};
    vecs[3] = '{b: '{8'hB5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                n: 4, data_off: 2, exp_writes: 1, exp_done: 1'b1, exp_err: 2'b00};
    vecs[4] = '{b: '{8'hB5, 8'h02, 8'h10, 8'h20, 8'hD0, 8'h00, 8'h00, 8'h00},
                n: 5, data_off: 2, exp_writes: 2, exp_done: 1'b1, exp_err: 2'b00};

    // Reset only: nothing happens for 100 cycles.
    do_reset();
    check_reset_outputs("rst");
    idle(100);
    chk("rst100_writes", wa.size(), 0);
    chk("rst100_cpu_hold", cpu_hold, 1);
    chk("rst100_rx_ready", rx_ready, 1);

    // Table of whole frames.
    foreach (vecs[v]) begin
      do_reset();
      for (int i = 0; i < int'(vecs[v].n); i++) send_byte(vecs[v].b[i]);
      idle(4);
      chk($sformatf("v%0d_load_done", v), load_done, vecs[v].exp_done);
      chk($sformatf("v%0d_cpu_hold", v), cpu_hold, !vecs[v].exp_done);
      chk($sformatf("v%0d_rx_ready", v), rx_ready, !vecs[v].exp_done);
      chk($sformatf("v%0d_load_error", v), load_error, vecs[v].exp_err);
      chk($sformatf("v%0d_state", v), loader_state, vecs[v].exp_done ? 3'd4 : 3'd0);
      chk($sformatf("v%0d_nwrites", v), wa.size(), vecs[v].exp_writes);
      chk($sformatf("v%0d_err_cycles", v), err_cycles, (vecs[v].exp_err != 2'b00) ? 1 : 0);
      if (wa.size() == int'(vecs[v].exp_writes)) begin
        for (int i = 0; i < wa.size(); i++) begin
          chk($sformatf("v%0d_waddr%0d", v, i), wa[i], i);
          chk($sformatf("v%0d_wdata%0d", v, i), wd[i], vecs[v].b[vecs[v].data_off + i]);
          chk($sformatf("v%0d_wcyc%0d", v, i), wc[i], wc[0] + i);
        end
        if (vecs[v].exp_done)
          chk($sformatf("v%0d_done_cyc", v), done_cyc, wc[wa.size()-1] + 1);
      end
    end

    // Checksum error then a good frame without reset.
    do_reset();
    foreach (vecs[1].b[i]) if (i < 5) send_byte(vecs[1].b[i]);
    send_byte(8'hB5);
    chk("recover_err_cleared", load_error, 0);
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'hFB);
    idle(2);
    chk("recover_done", load_done, 1);
    chk("recover_cpu_hold", cpu_hold, 0);
    chk("recover_nwrites", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("recover_last_addr", wa[2], 8'h00);
      chk("recover_last_data", wd[2], 8'h05);
    end

    // Timeout inside DATA: ERROR is entered exactly T cycles after the last byte.
    do_reset();
    send_byte(8'hB5);
    send_byte(8'h02);
    send_byte(8'h10);
    rx_valid = 1'b0;
    k = -1;
    for (int i = 1; i <= int'(4 * T); i++) begin
      @(posedge clk);
      #1;
      if (loader_state == 3'd5) begin
        k = i;
        break;
      end
    end
    chk("tmo_latency", k, T);
    chk("tmo_error_code", load_error, 2'b10);
    chk("tmo_cpu_hold", cpu_hold, 1);
    idle(1);
    chk("tmo_back_to_sync", loader_state, 0);
    chk("tmo_error_held", load_error, 2'b10);
    send_byte(8'h10);
    send_byte(8'hFF);
    idle(2);
    chk("tmo_dropped_state", loader_state, 0);
    chk("tmo_dropped_writes", wa.size(), 1);
    send_byte(8'hB5);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'h56);
    idle(2);
    chk("tmo_reload_done", load_done, 1);
    chk("tmo_reload_err", load_error, 0);
    if (wa.size() == 2) chk("tmo_reload_data", wd[1], 8'hAA);
    else chk("tmo_reload_nwrites", wa.size(), 2);

    // Byte offered in the expiring cycle is refused.
    do_reset();
    send_byte(8'hB5);
    send_byte(8'h02);
    send_byte(8'h10);
    idle(int'(T) - 1);
    rx_data  = 8'h20;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("tmo_edge_rx_ready", rx_ready, 0);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    chk("tmo_edge_state", loader_state, 3'd5);
    chk("tmo_edge_err", load_error, 2'b10);
    idle(2);
    chk("tmo_edge_nwrites", wa.size(), 1);

    // LEN=0: 256 bytes of 01 across the whole address range.
    do_reset();
    send_byte(8'hB5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'h01);
    chk("big_not_done_before_csum", load_done, 0);
    send_byte(8'h00);
    idle(2);
    chk("big_nwrites", wa.size(), 256);
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== i[7:0] || wd[i] !== 8'h01 || wc[i] != wc[0] + i) bad++;
    chk("big_write_errors", bad, 0);
    chk("big_done", load_done, 1);
    chk("big_cpu_hold", cpu_hold, 0);

    // Asynchronous reset right after the 2nd data byte.
    do_reset();
    send_byte(8'hB5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("midrst_write_live", mem_we, 1);
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
    for (int i = 0; i < int'(vecs[0].n); i++) send_byte(vecs[0].b[i]);
    idle(2);
    chk("midrst_reload_done", load_done, 1);
    chk("midrst_reload_nwrites", wa.size(), 3);
    if (wa.size() == 3) chk("midrst_reload_w2", {wa[2], wd[2]}, 16'h0233);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/boruss_program_loader.md
# boruss_program_loader

Byte-stream program loader that sits upstream of the Boruss CPU core and its memory controller. It receives a framed program image over a valid/ready byte interface, typically from the UART receiver, and writes it into program memory starting at address 0x00. It holds the CPU in reset until a frame with a correct checksum has been written. After a successful load it releases the CPU and stops accepting input until the next reset.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 100000: idle cycles allowed between accepted bytes inside a frame before the frame is aborted.
- SYNC_BYTE, default 8'hB5: frame header value.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte. A byte transfers on a cycle where rx_valid && rx_ready.
- mem_we  out  1  one-cycle program-memory write strobe.
- mem_addr  out  8  write address.
- mem_wdata  out  8  write data.
- cpu_hold  out  1  drives the CPU core reset; high while the program is not loaded.
- load_done  out  1  successful load completed; sticky until reset.
- load_error  out  2  last error: 00 none, 01 checksum, 10 timeout.
- loader_state  out  3  current FSM state, for debug.

## Operation
- Frame format: SYNC_BYTE, then LEN, then LEN data bytes, then CSUM.
  - LEN 0 means 256 bytes.
  - A frame is valid when the 8-bit sum of all data bytes plus CSUM equals 0 (mod 256).
- FSM states and encodings: SYNC=0, LEN=1, DATA=2, CSUM=3, DONE=4, ERROR=5.
- SYNC:
  - Accepted bytes not equal to SYNC_BYTE are dropped.
  - SYNC_BYTE moves to LEN, clears load_error to 00, clears the byte index and the checksum accumulator.
- LEN:
  - The accepted byte is latched as the remaining count (0 is loaded as 256, 9-bit counter).
  - Next state is DATA.
- DATA:
  - Each accepted byte is added to the accumulator (8-bit wrap) and written to memory.
  - Write occurs at mem_addr = index; the index is then incremented (8-bit wrap from 0xFF to 0x00) and the count is decremented.
  - When the count reaches 0 after a byte, next state is CSUM.
- CSUM:
  - On acceptance, if accumulator + byte == 0 the next state is DONE.
  - Otherwise load_error becomes 01 and the next state is ERROR.
- DONE: terminal until reset. rx_ready=0, cpu_hold=0, load_done=1.
- ERROR:
  - Lasts exactly one cycle with rx_ready=0, then returns to SYNC.
  - cpu_hold stays 1; load_error is held.
- Timeout:
  - An idle counter runs in LEN, DATA and CSUM.
  - It clears on every accepted byte and on every state entry.
  - When it reaches TIMEOUT_CYCLES, load_error becomes 10 and the next state is ERROR, even if a byte is offered in that cycle (that byte is not accepted).
- Memory already written by an aborted frame is not restored. The next valid frame overwrites it.

## Timing
- All outputs are registered except rx_ready, which is decoded combinationally from state (1 in SYNC/LEN/DATA/CSUM).
- Reset values: state SYNC, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_error=00, loader_state=0.
- Reset mid-frame returns everything to these values immediately (asynchronous reset).
- Write latency: mem_we, mem_addr and mem_wdata are asserted in the cycle after a data byte is accepted, for one cycle only. Back-to-back bytes produce back-to-back writes.
- DONE entry: cpu_hold falls and load_done rises in the cycle after the CSUM byte is accepted. The last data write has completed at least one cycle earlier.
- Throughput: one byte per cycle. rx_valid may stay high continuously.

## Structure
- Package boruss_loader_pkg holds:
  - the state encodings;
  - the load_error codes (ERR_NONE, ERR_CSUM, ERR_TIMEOUT);
  - the default SYNC_BYTE.
- Sub-module boruss_loader_timeout: a parameterised idle counter with a clear input and an expired output. It is the one natural split.
- Top level integration: mem_* connect to the memory controller's program-write port, and cpu_hold is ORed into the CPU core reset.

## Test plan
- Reset only -> cpu_hold=1, rx_ready=1, no mem_we over 100 cycles.
- Stream B5 03 11 22 33 9A with rx_valid held high:
  - writes (00,11), (01,22), (02,33) on consecutive cycles;
  - then load_done=1, cpu_hold=0, rx_ready=0.
- Stream B5 02 10 20 00 -> load_error=01, a one-cycle ERROR, back to SYNC with cpu_hold=1. A following valid frame clears the error and completes.
- Stream B5 02 10, then TIMEOUT_CYCLES idle cycles -> load_error=10 and return to SYNC. Bytes 10 FF before a B5 are then dropped.
- Stream B5 00 with 256 bytes of value 01, then CSUM 00 -> 256 writes with addresses 00..FF, then DONE.
- Assert reset after the 2nd data byte of a frame -> all outputs return to reset values immediately. A fresh frame then loads correctly.
